acc_readout: RTL

ACC_READOUT -- requirements
Module: acc_readout

---
 rtl/cim_pkg.sv | 7 +
 rtl/acc_readout_fifo.sv | 39 +++
 rtl/acc_readout.sv | 89 ++++++++
 3 files changed

// File: rtl/cim_pkg.sv
// cim_pkg: shared readout widths and the packed output-word type seen by global_io consumers.
package cim_pkg;
  localparam int ACC_W_DEF = 36;
  localparam int OUT_W_DEF = 8;
  localparam int LANES_DEF = 4;
  typedef logic [LANES_DEF*OUT_W_DEF-1:0] acc_word_t;
endpackage

// File: rtl/acc_readout_fifo.sv
// acc_readout_fifo: registered synchronous FIFO with occupancy count; pops on an empty FIFO are ignored.
module acc_readout_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH):0]     occ
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign out_valid = occ != '0;
  assign out_data = out_valid ? mem[rp] : '0;
  assign do_pop = out_ready && out_valid;
  assign do_push = push && (occ != CW'(DEPTH) || do_pop);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= push_data;
        wp <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      occ <= occ + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/acc_readout.sv
// acc_readout: requantizes final accumulator samples, packs lanes into words and queues them in a FIFO.
// Define ACC_READOUT_RELU_EN to clamp negative results to zero before saturation.
module acc_readout
  import cim_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACC_W-1:0]       in_data,
  input  logic                   in_last,
  input  logic [4:0]             shift,
  input  logic                   flush,
  input  logic                   clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   sat_flag
);
  localparam int W = LANES * OUT_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W:0] LO = ~HI;
  logic signed [ACC_W:0] sum, r_raw, r;
  logic [OUT_W-1:0] q, s1_lane;
  logic clamp, take, s1_valid, last_lane, push;
  logic [LW-1:0] cnt;
  logic [W-1:0] word, merged, push_data;
  logic [CW-1:0] occ;
  // one slot stays free for the lane already sitting in s1
  assign in_ready = occ <= CW'(FIFO_DEPTH - 2);
  assign take = in_valid && in_ready && in_last;
  always_comb begin
    sum = {in_data[ACC_W-1], in_data} + (shift == 5'd0 ? '0 : (ACC_W+1)'(1) << (shift - 5'd1));
    r_raw = sum >>> shift;
`ifdef ACC_READOUT_RELU_EN
    r = r_raw[ACC_W] ? '0 : r_raw;
`else
    r = r_raw;
`endif
    clamp = r > HI || r < LO;
    q = r > HI ? HI[OUT_W-1:0] : r < LO ? LO[OUT_W-1:0] : r[OUT_W-1:0];
  end
  assign last_lane = cnt == LW'(LANES - 1);
  assign merged = word | (W'(s1_lane) << (32'(cnt) * OUT_W));
  assign push = !clr && (s1_valid ? (last_lane || flush) : (flush && cnt != '0));
  assign push_data = s1_valid ? merged : word;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_lane <= '0;
      cnt <= '0;
      word <= '0;
      sat_flag <= 1'b0;
    end else if (clr) begin
      s1_valid <= 1'b0;
      cnt <= '0;
      word <= '0;
      sat_flag <= 1'b0;
    end else begin
      s1_valid <= take;
      if (take) s1_lane <= q;
      if (take && clamp) sat_flag <= 1'b1;
      if (push) begin
        cnt <= '0;
        word <= '0;
      end else if (s1_valid) begin
        cnt <= cnt + LW'(1);
        word <= merged;
      end
    end
  end
  acc_readout_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .push(push),
    .push_data(push_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .occ(occ)
  );
endmodule
